// File: rtl/hazard_scheduler_pkg.sv
// hazard_scheduler_pkg: opcodes, instruction fields, forwarding encodings and FSM states for the scheduler
package hazard_scheduler_pkg;
  localparam int OPC_HI = 23;
  localparam int OPC_LO = 19;
  localparam int RD_HI = 18;
  localparam int RD_LO = 16;
  localparam int RA_HI = 15;
  localparam int RA_LO = 13;
  localparam int RB_HI = 12;
  localparam int RB_LO = 10;
  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_LOAD = 5'b10100;
  localparam logic [4:0] OP_STORE = 5'b10101;
  localparam logic [4:0] OP_JUMP = 5'b10001;
  localparam logic [4:0] OP_HALT = 5'b11110;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  typedef enum logic [1:0] {S_RUN, S_JFLUSH, S_HALT} state_t;
  typedef struct packed {
    logic [4:0] op;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
  } ins_f_t;
  function automatic logic writes_rd(input logic [4:0] op);
    return !(op == OP_NOP || op == OP_STORE || op == OP_JUMP || op == OP_HALT);
  endfunction
  function automatic logic reads_src(input logic [4:0] op);
    return !(op == OP_NOP || op == OP_JUMP || op == OP_HALT);
  endfunction
  // a matching load in EX always stalls, so it never reaches this choice as a live source
  function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic ex_load, input logic mem_hit);
    return (ex_hit && !ex_load) ? FWD_EXMEM : mem_hit ? FWD_MEMWB : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_scheduler_tracker.sv
// hazard_tracker: EX/MEM/WB destination shift registers with source-register match outputs
module hazard_tracker
  import hazard_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  input  logic [2:0] i_rd,
  input  logic       i_is_load,
  input  logic [2:0] i_src_a,
  input  logic [2:0] i_src_b,
  output logic       o_ex_hit_a,
  output logic       o_ex_hit_b,
  output logic       o_mem_hit_a,
  output logic       o_mem_hit_b,
  output logic       o_ex_load,
  output logic       o_empty
);
  // r_v[0]=EX, r_v[1]=MEM, r_v[2]=WB; only writers are marked valid
  logic [2:0] r_v;
  logic [2:0] r_rd_ex;
  logic [2:0] r_rd_mem;
  logic       r_ld_ex;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= '0;
      r_rd_ex <= '0;
      r_rd_mem <= '0;
      r_ld_ex <= 1'b0;
    end else begin
      r_v <= {r_v[1:0], i_valid};
      r_rd_ex <= i_rd;
      r_rd_mem <= r_rd_ex;
      r_ld_ex <= i_is_load;
    end
  end
  assign o_ex_hit_a = r_v[0] && i_src_a != 3'd0 && r_rd_ex == i_src_a;
  assign o_ex_hit_b = r_v[0] && i_src_b != 3'd0 && r_rd_ex == i_src_b;
  assign o_mem_hit_a = r_v[1] && i_src_a != 3'd0 && r_rd_mem == i_src_a;
  assign o_mem_hit_b = r_v[1] && i_src_b != 3'd0 && r_rd_mem == i_src_b;
  assign o_ex_load = r_v[0] && r_ld_ex;
  assign o_empty = ~|r_v;
endmodule

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: load-use stall, jump flush, halt freeze and EX forwarding selects for the 5-stage pipe
module hazard_scheduler
  import hazard_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] ins,
  input  logic        ins_valid,
  output logic        stall,
  output logic        stall_pm,
  output logic        flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        halted
);
  state_t r_state, w_next;
  ins_f_t w_f;
  logic [1:0] r_fwd_a, r_fwd_b;
  logic w_unused;
  logic w_reads, w_adv, w_hazard;
  logic [2:0] w_src_a, w_src_b;
  logic w_ex_hit_a, w_ex_hit_b, w_mem_hit_a, w_mem_hit_b, w_ex_load, w_empty;
  assign w_f = ins_f_t'(ins[OPC_HI:RB_LO]);
  assign w_unused = ^ins[RB_LO-1:0];
  // r0 doubles as "no source", so non-reading slots can never match
  assign w_reads = ins_valid && reads_src(w_f.op);
  assign w_src_a = w_reads ? w_f.ra : 3'd0;
  assign w_src_b = w_reads ? w_f.rb : 3'd0;
  assign w_hazard = r_state == S_RUN && w_ex_load && (w_ex_hit_a || w_ex_hit_b);
  assign w_adv = r_state == S_RUN && !w_hazard && ins_valid;
  hazard_tracker u_trk (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (w_adv && writes_rd(w_f.op)),
    .i_rd       (w_f.rd),
    .i_is_load  (w_f.op == OP_LOAD),
    .i_src_a    (w_src_a),
    .i_src_b    (w_src_b),
    .o_ex_hit_a (w_ex_hit_a),
    .o_ex_hit_b (w_ex_hit_b),
    .o_mem_hit_a(w_mem_hit_a),
    .o_mem_hit_b(w_mem_hit_b),
    .o_ex_load  (w_ex_load),
    .o_empty    (w_empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else begin
      r_state <= w_next;
      r_fwd_a <= w_adv ? fwd_pick(w_ex_hit_a, w_ex_load, w_mem_hit_a) : FWD_RF;
      r_fwd_b <= w_adv ? fwd_pick(w_ex_hit_b, w_ex_load, w_mem_hit_b) : FWD_RF;
    end
  end
  always_comb begin
    w_next = r_state == S_JFLUSH ? S_RUN :
             (w_adv && w_f.op == OP_JUMP) ? S_JFLUSH :
             (w_adv && w_f.op == OP_HALT) ? S_HALT : r_state;
    stall = w_hazard || r_state == S_HALT;
    stall_pm = w_hazard || r_state == S_HALT;
    flush = r_state == S_JFLUSH;
    halted = r_state == S_HALT && w_empty;
  end
  assign fwd_a_sel = r_fwd_a;
  assign fwd_b_sel = r_fwd_b;
endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: instruction-level pipeline model feeding a scoreboard checked every cycle
module tb_hazard_scheduler;
  localparam logic [4:0] L_NOP = 5'b00000;
  localparam logic [4:0] L_LOAD = 5'b10100;
  localparam logic [4:0] L_STORE = 5'b10101;
  localparam logic [4:0] L_JUMP = 5'b10001;
  localparam logic [4:0] L_HALT = 5'b11110;
  logic clk = 1'b0;
  logic reset, ins_valid;
  logic [23:0] ins;
  logic stall, stall_pm, flush, halted;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  typedef struct packed {logic v; logic [23:0] w;} slot_t;
  slot_t pipe [3];
  bit m_flush, m_halt, m_known;
  logic [8:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  hazard_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .ins      (ins),
    .ins_valid(ins_valid),
    .stall    (stall),
    .stall_pm (stall_pm),
    .flush    (flush),
    .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel),
    .halted   (halted)
  );
  function automatic logic [23:0] mk(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 10'd0};
  endfunction
  function automatic bit writes(input logic [23:0] w);
    return !(w[23:19] inside {L_NOP, L_STORE, L_JUMP, L_HALT});
  endfunction
  function automatic bit reads(input logic [23:0] w);
    return !(w[23:19] inside {L_NOP, L_JUMP, L_HALT});
  endfunction
  function automatic bit writer(input slot_t s, input logic [2:0] r);
    return s.v && writes(s.w) && r != 3'd0 && s.w[18:16] == r;
  endfunction
  function automatic logic [1:0] fwd_for(input logic [2:0] r);
    if (!(pipe[0].v && reads(pipe[0].w))) return 2'b00;
    if (writer(pipe[1], r)) return 2'b01;
    if (writer(pipe[2], r)) return 2'b10;
    return 2'b00;
  endfunction
  task automatic step(input logic [23:0] w, input logic v, input logic r, output bit stalled);
    bit hz, adv, hlt;
    logic [2:0] ld_rd;
    ins = w;
    ins_valid = v;
    reset = r;
    ld_rd = pipe[0].w[18:16];
    hz = !m_halt && !m_flush && v && reads(w) && pipe[0].v && pipe[0].w[23:19] == L_LOAD &&
         ld_rd != 3'd0 && (ld_rd == w[15:13] || ld_rd == w[12:10]);
    hlt = m_halt;
    for (int i = 0; i < 3; i++) if (pipe[i].v && writes(pipe[i].w)) hlt = 1'b0;
    if (m_known) exp_q.push_back({hz || m_halt, hz || m_halt, m_flush,
                                  fwd_for(pipe[0].w[15:13]), fwd_for(pipe[0].w[12:10]), hlt});
    stalled = hz;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      m_flush = 0;
      m_halt = 0;
      m_known = 1;
    end else if (m_known) begin
      adv = !m_halt && !m_flush && !hz && v;
      m_flush = adv && w[23:19] == L_JUMP;
      m_halt = m_halt || (adv && w[23:19] == L_HALT);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = adv ? {1'b1, w} : '0;
    end
  endtask
  task automatic issue(input logic [23:0] w);
    bit s;
    int k = 0;
    do begin
      step(w, 1'b1, 1'b0, s);
      k++;
    end while (s && k < 4);
  endtask
  function automatic logic [23:0] rand_ins();
    int k;
    logic [4:0] op;
    k = $urandom_range(0, 39);
    op = k < 4 ? L_NOP : k < 12 ? L_LOAD : k < 15 ? L_STORE : k < 17 ? L_JUMP : k == 17 ? L_HALT :
         5'($urandom_range(1, 7));
    return {op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 10'($urandom)};
  endfunction
  always @(negedge clk) begin
    logic [8:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {stall, stall_pm, flush, fwd_a_sel, fwd_b_sel, halted};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t {stall,stall_pm,flush,fwd_a,fwd_b,halted} got=%b exp=%b", $time, a, e);
      end
    end
  end
  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    bit s;
    m_known = 0;
    step(24'ha00000, 1'b1, 1'b1, s);
    step(24'ha00000, 1'b1, 1'b1, s);
    issue(mk(5'd1, 3'd2, 3'd1, 3'd1));
    issue(mk(5'd3, 3'd5, 3'd2, 3'd0));
    repeat (3) issue(24'h0);
    issue(mk(5'd1, 3'd2, 3'd1, 3'd1));
    issue(mk(5'd1, 3'd6, 3'd1, 3'd1));
    issue(mk(5'd3, 3'd5, 3'd2, 3'd0));
    repeat (3) issue(24'h0);
    issue(24'ha30000);
    issue(mk(5'd2, 3'd4, 3'd0, 3'd3));
    repeat (3) issue(24'h0);
    issue(mk(L_LOAD, 3'd0, 3'd0, 3'd0));
    issue(mk(5'd2, 3'd4, 3'd0, 3'd0));
    repeat (3) issue(24'h0);
    issue(24'h880000);
    issue(mk(5'd1, 3'd3, 3'd0, 3'd0));
    issue(mk(5'd2, 3'd4, 3'd3, 3'd3));
    repeat (3) issue(24'h0);
    issue(mk(5'd1, 3'd1, 3'd0, 3'd0));
    issue(mk(5'd1, 3'd2, 3'd0, 3'd0));
    issue(mk(5'd1, 3'd3, 3'd0, 3'd0));
    issue(24'hf00000);
    repeat (6) step(24'h0, 1'b1, 1'b0, s);
    step(24'ha00000, 1'b1, 1'b1, s);
    repeat (2) issue(24'h0);
    issue(24'ha30000);
    issue(mk(5'd2, 3'd4, 3'd3, 3'd3));
    issue(24'h880000);
    step(mk(5'd1, 3'd3, 3'd3, 3'd3), 1'b1, 1'b1, s);
    repeat (2) issue(24'h0);
    for (int i = 0; i < 3000; i++) begin
      if (m_halt) begin
        repeat (5) step(rand_ins(), 1'($urandom_range(0, 1)), 1'b0, s);
        step(rand_ins(), 1'b1, 1'b1, s);
      end else if ($urandom_range(0, 7) != 0) issue(rand_ins());
      else step(rand_ins(), 1'b0, 1'b0, s);
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
